line_buffer_frame_ctrl: RTL and testbench
=========================================

// Module: line_buffer_frame_ctrl
// PURPOSE
//  Frame sequencer in front of the 3-line image line buffer. Frames each input pixel stream:
//   latches img_width/img_height at start of frame and holds them stable all frame; forwards pixels.
//  After the last pixel it injects one zero-filled flush line so the final row leaves the window.
//  Counts window outputs, pulses frame_done, then clears the line buffer before the next frame.
// PARAMETERS
//  DATA_W     8    pixel width
//  W_BITS     11   width of img_width and the column counter
//  H_BITS     10   width of img_height and the row counter
//  FLUSH_VAL  0    pixel value driven during the flush line
// PORTS
//  clk          in   1       system clock
//  reset        in   1       synchronous, active-high reset
//  cfg_width    in   W_BITS  frame width; sampled on the SOF handshake
//  cfg_height   in   H_BITS  frame height; sampled on the SOF handshake
//  in_valid     in   1       input pixel valid
//  in_ready     out  1       input pixel accepted when in_valid && in_ready
//  in_data      in   DATA_W  input pixel
//  in_sof       in   1       first pixel of frame
//  in_eol       in   1       last pixel of line
//  err_clr      in   1       clears the sticky error flags
//  lb_reset     out  1       reset to the line buffer
//  lb_img_width out  W_BITS  latched width to the line buffer
//  lb_img_height out H_BITS  latched height to the line buffer
//  lb_valid     out  1       pixel strobe to the line buffer
//  lb_data      out  DATA_W  pixel to the line buffer
//  lb_valid_o   in   1       window-valid returned from the line buffer
//  busy         out  1       high whenever state != IDLE
//  frame_done   out  1       1-cycle pulse when all width*height windows are out
//  err_eol      out  1       sticky: in_eol disagrees with the column counter
//  err_cfg      out  1       sticky: SOF seen with cfg_width<2 or cfg_height<2
// BEHAVIOUR
//  Reset: state=IDLE; lb_valid, lb_data, frame_done, err_eol, err_cfg, counters=0.
//   lb_img_width/lb_img_height=0. lb_reset=1 while reset is high.
//  in_ready=1 in IDLE and RUN, 0 in FLUSH/DRAIN/CLEAR. Decoded from the state register only.
//  lb_valid/lb_data registered: 1 cycle after the accepted handshake. Throughput 1 pixel/clk.
//  IDLE: accepted pixel without in_sof is discarded (resync).
//   accepted SOF with legal cfg -> latch dims, forward pixel, col=1, row=0 -> RUN.
//   accepted SOF with illegal cfg -> drop pixel, set err_cfg, stay IDLE.
//  RUN: forward each accepted pixel. col wraps at lb_img_width-1; row increments on the wrap.
//   Mid-frame in_sof is ignored.
//   in_eol xor (col==w-1) on accepted pixel -> set err_eol; counters follow the latched width.
//   Accepted pixel with col==w-1 && row==h-1 -> FLUSH.
//  FLUSH: emit exactly w beats lb_valid=1, lb_data=FLUSH_VAL, back-to-back -> DRAIN.
//  DRAIN: out_cnt (W_BITS+H_BITS bits) counts lb_valid_o.
//   When out_cnt reaches w*h -> frame_done=1 for one cycle -> CLEAR.
//  CLEAR: lb_reset=1 for exactly 1 cycle; out_cnt=0 -> IDLE.
//  lb_img_width/lb_img_height change only on the SOF latch; never during RUN/FLUSH/DRAIN.
//  err_clr in the same cycle as a set event: set wins.
//  Reset mid-frame: immediate return to IDLE, partial frame abandoned, no frame_done.
//   lb_reset is high during reset, so the line buffer clears with it.
//  w*h product: compute once at latch into a registered W_BITS+H_BITS-bit value.
//   No per-cycle multiply.
// STRUCTURE
//  Shared header img_pkg.vh:
//   - state encodings IDLE/RUN/FLUSH/DRAIN/CLEAR
//   - W_BITS/H_BITS/DATA_W defaults
//   - MIN_DIM=2
//  Sub-module frame_pos_counter (col/row counter with enable, wrap at width/height, last flag).
//   Used for RUN; the FLUSH beat count reuses the column part.
// TESTING
//  1 4x3 frame, continuous valid -> 12 fwd + 4 flush beats. Feed 12 lb_valid_o -> frame_done.
//    Then lb_reset pulses once, back in IDLE.
//  2 4x3 frame, in_valid toggling 1/0 -> lb_valid gaps match input gaps, in_ready=0 in FLUSH.
//    lb_data equals the input sequence.
//  3 3 non-SOF pixels, then a SOF 4x3 frame -> first 3 dropped.
//    lb_valid only for frame pixels, lb_img_width=4.
//  4 SOF with cfg_width=1 -> err_cfg=1, no lb_valid, stay IDLE.
//    err_clr -> err_cfg=0; next legal SOF runs normally.
//  5 in_eol at col 2 of width-4 frame -> err_eol=1, frame still ends after 12 pixels.
//    cfg_width changed mid-frame -> lb_img_width unchanged.
//  6 reset asserted at pixel 7 of 4x3 -> next clk: state IDLE, lb_valid=0, no frame_done.
//    lb_reset=1 during reset; new frame then completes cleanly.

Source files
------------

// File: rtl/line_buffer_frame_ctrl_pkg.sv
// rtl/line_buffer_frame_ctrl_pkg.sv - shared constants for the line buffer frame sequencer
//
// Purpose: state encodings, default widths and the minimum legal frame
//          dimension shared by line_buffer_frame_ctrl and frame_pos_counter.
// Ports:   none (package).

package line_buffer_frame_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_W_BITS = 11;
  localparam int DEF_H_BITS = 10;

  // A 3-line window needs at least two columns and two rows to be meaningful.
  localparam int unsigned MIN_DIM = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  function automatic logic dims_ok(input int unsigned w, input int unsigned h);
    return (w >= MIN_DIM) && (h >= MIN_DIM);
  endfunction

endpackage

// File: rtl/line_buffer_frame_ctrl_pos.sv
// rtl/line_buffer_frame_ctrl_pos.sv - column/row position counter for the frame sequencer
//
// Purpose: frame_pos_counter tracks (col,row) inside a frame. col wraps at
//          width-1 and row advances on that wrap, wrapping at height-1.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   load         load col=load_col, row=0 (has priority over en)
//   en           advance the position by one pixel
//   load_col     column value applied on load
//   width/height latched frame dimensions
//   col_last     col == width-1
//   last         col == width-1 and row == height-1

module frame_pos_counter
  import line_buffer_frame_ctrl_pkg::*;
#(
  parameter int W_BITS = DEF_W_BITS,
  parameter int H_BITS = DEF_H_BITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic [W_BITS-1:0] load_col,
  input  logic [W_BITS-1:0] width,
  input  logic [H_BITS-1:0] height,
  output logic              col_last,
  output logic              last
);

  localparam logic [W_BITS-1:0] W_ONE = W_BITS'(1);
  localparam logic [H_BITS-1:0] H_ONE = H_BITS'(1);

  logic [W_BITS-1:0] col;
  logic [H_BITS-1:0] row;
  logic              row_last;

  assign col_last = (col == width - W_ONE);
  assign row_last = (row == height - H_ONE);
  assign last     = col_last && row_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= load_col;
      row <= '0;
    end else if (en) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + H_ONE;
      end else begin
        col <= col + W_ONE;
      end
    end
  end

endmodule

// File: rtl/line_buffer_frame_ctrl.sv
// rtl/line_buffer_frame_ctrl.sv - frame sequencer in front of the 3-line image line buffer
//
// Purpose: frames the input pixel stream, latches the frame size on SOF,
//          forwards pixels, appends one FLUSH_VAL line, waits for all
//          width*height windows, pulses frame_done and clears the line buffer.
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   cfg_width, cfg_height       frame size, sampled on the SOF handshake
//   in_valid/in_ready/in_data   input pixel handshake
//   in_sof, in_eol              first pixel of frame / last pixel of line
//   err_clr                     clears sticky error flags
//   lb_reset                    line buffer reset (reset or CLEAR state)
//   lb_img_width/lb_img_height  latched frame size to the line buffer
//   lb_valid/lb_data            registered pixel strobe to the line buffer
//   lb_valid_o                  window-valid returned by the line buffer
//   busy                        state != IDLE
//   frame_done                  one-cycle pulse when all windows are out
//   err_eol, err_cfg            sticky line-length / configuration errors

module line_buffer_frame_ctrl
  import line_buffer_frame_ctrl_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                W_BITS    = DEF_W_BITS,
  parameter int                H_BITS    = DEF_H_BITS,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [W_BITS-1:0] cfg_width,
  input  logic [H_BITS-1:0] cfg_height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eol,
  input  logic              err_clr,
  output logic              lb_reset,
  output logic [W_BITS-1:0] lb_img_width,
  output logic [H_BITS-1:0] lb_img_height,
  output logic              lb_valid,
  output logic [DATA_W-1:0] lb_data,
  input  logic              lb_valid_o,
  output logic              busy,
  output logic              frame_done,
  output logic              err_eol,
  output logic              err_cfg
);

  localparam int P_BITS = W_BITS + H_BITS;
  localparam logic [W_BITS-1:0] W_ONE = W_BITS'(1);

  logic [2:0]        state;
  logic [P_BITS-1:0] wh;
  logic [P_BITS-1:0] out_cnt;
  logic [P_BITS-1:0] out_cnt_nxt;
  logic              accept;
  logic              cfg_ok;
  logic              sof_ok;
  logic              set_cfg;
  logic              set_eol;
  logic              cnt_load;
  logic              cnt_en;
  logic [W_BITS-1:0] load_col;
  logic              col_last;
  logic              pos_last;

  assign in_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign busy     = (state != ST_IDLE);
  assign lb_reset = reset || (state == ST_CLEAR);
  assign accept   = in_valid && in_ready;

  assign cfg_ok  = dims_ok(32'(cfg_width), 32'(cfg_height));
  assign sof_ok  = (state == ST_IDLE) && accept && in_sof && cfg_ok;
  assign set_cfg = (state == ST_IDLE) && accept && in_sof && !cfg_ok;
  assign set_eol = (state == ST_RUN) && accept && (in_eol != col_last);

  assign out_cnt_nxt = out_cnt + P_BITS'(lb_valid_o);

  // The SOF pixel is forwarded on the latch cycle, so the counter starts at
  // col=1. The last frame pixel reloads col=0 so the same column counter
  // then paces the w flush beats.
  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    load_col = '0;
    case (state)
      ST_IDLE: begin
        if (sof_ok) begin
          cnt_load = 1'b1;
          load_col = W_ONE;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (pos_last) cnt_load = 1'b1;
          else          cnt_en   = 1'b1;
        end
      end
      ST_FLUSH: cnt_en = 1'b1;
      default: ;
    endcase
  end

  frame_pos_counter #(
    .W_BITS (W_BITS),
    .H_BITS (H_BITS)
  ) u_pos (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_col (load_col),
    .width    (lb_img_width),
    .height   (lb_img_height),
    .col_last (col_last),
    .last     (pos_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      lb_img_width  <= '0;
      lb_img_height <= '0;
      lb_valid      <= 1'b0;
      lb_data       <= '0;
      wh            <= '0;
      out_cnt       <= '0;
      frame_done    <= 1'b0;
      err_eol       <= 1'b0;
      err_cfg       <= 1'b0;
    end else begin
      lb_valid   <= 1'b0;
      frame_done <= 1'b0;

      // A set event in the same cycle as err_clr keeps the flag set.
      if (set_cfg)      err_cfg <= 1'b1;
      else if (err_clr) err_cfg <= 1'b0;
      if (set_eol)      err_eol <= 1'b1;
      else if (err_clr) err_eol <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Non-SOF pixels and illegal SOFs are consumed and dropped here.
          if (sof_ok) begin
            lb_img_width  <= cfg_width;
            lb_img_height <= cfg_height;
            wh            <= P_BITS'(cfg_width) * P_BITS'(cfg_height);
            lb_valid      <= 1'b1;
            lb_data       <= in_data;
            state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The line buffer already emits windows while later rows stream
          // in, so window counting starts with the frame, not at DRAIN.
          out_cnt <= out_cnt_nxt;
          if (accept) begin
            lb_valid <= 1'b1;
            lb_data  <= in_data;
            if (pos_last) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          out_cnt  <= out_cnt_nxt;
          lb_valid <= 1'b1;
          lb_data  <= FLUSH_VAL;
          if (col_last) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          out_cnt <= out_cnt_nxt;
          if (out_cnt_nxt >= wh) begin
            frame_done <= 1'b1;
            state      <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          out_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_buffer_frame_ctrl.sv
// tb/tb_line_buffer_frame_ctrl.sv - self-checking bench for line_buffer_frame_ctrl
//
// Purpose: drives framed pixel streams with random data/gaps and checks the
//          forwarded stream, flush line, handshake, errors and frame_done.
// Ports:   none (top-level bench).

module tb_line_buffer_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] cfg_width;
  logic [9:0]  cfg_height;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        in_eol;
  logic        err_clr;
  logic        lb_reset;
  logic [10:0] lb_img_width;
  logic [9:0]  lb_img_height;
  logic        lb_valid;
  logic [7:0]  lb_data;
  logic        lb_valid_o;
  logic        busy;
  logic        frame_done;
  logic        err_eol;
  logic        err_cfg;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int clr_cnt = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  line_buffer_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_width     (cfg_width),
    .cfg_height    (cfg_height),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sof        (in_sof),
    .in_eol        (in_eol),
    .err_clr       (err_clr),
    .lb_reset      (lb_reset),
    .lb_img_width  (lb_img_width),
    .lb_img_height (lb_img_height),
    .lb_valid      (lb_valid),
    .lb_data       (lb_data),
    .lb_valid_o    (lb_valid_o),
    .busy          (busy),
    .frame_done    (frame_done),
    .err_eol       (err_eol),
    .err_cfg       (err_cfg)
  );

  always @(negedge clk) begin
    if (lb_valid) got_q.push_back(lb_data);
    if (frame_done) done_cnt++;
    if (lb_reset && !reset) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete frame: pixels, flush line, window return, frame_done, clear.
  task automatic run_frame(input int w, input int h, input bit gaps,
                           input int bad_eol, input bit wiggle);
    int   n;
    int   idx;
    bit   v;
    bit   prev_v;
    int   done0;
    int   clr0;
    logic [7:0] px;
    n = w * h;
    idx = 0;
    prev_v = 1'b0;
    got_q.delete();
    exp_q.delete();
    cfg_width  = 11'(w);
    cfg_height = 10'(h);
    while (idx < n) begin
      v  = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      px = 8'($urandom);
      in_valid = v;
      in_data  = px;
      in_sof   = (idx == 0);
      in_eol   = ((idx % w) == w - 1) || (idx == bad_eol);
      if (wiggle && idx > 0) cfg_width = 11'($urandom_range(2, 60));
      @(negedge clk);
      check("in_ready_run", 32'(in_ready), 1);
      check("lb_valid_follows_input", 32'(lb_valid), 32'(prev_v));
      step();
      if (v) begin
        exp_q.push_back(px);
        idx++;
      end
      prev_v = v;
    end
    // Offer junk while the sequencer is flushing/draining; it must be refused.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    for (int k = 0; k < w + 2; k++) begin
      @(negedge clk);
      check("in_ready_flush", 32'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    cfg_width = 11'(w);
    for (int k = 0; k < w; k++) exp_q.push_back(8'h00);
    step();
    check("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("beat_%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check("lb_img_width", 32'(lb_img_width), w);
    check("lb_img_height", 32'(lb_img_height), h);
    check("busy_drain", 32'(busy), 1);
    done0 = done_cnt;
    clr0  = clr_cnt;
    for (int k = 0; k < n; k++) begin
      lb_valid_o = 1'b0;
      if (gaps && $urandom_range(0, 1) == 1) step();
      lb_valid_o = 1'b1;
      @(negedge clk);
      if (k == 0 || k == n - 1) check("no_early_done", 32'(frame_done), 0);
      step();
    end
    lb_valid_o = 1'b0;
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 1);
    check("lb_reset_clear", 32'(lb_reset), 1);
    step();
    @(negedge clk);
    check("frame_done_once", 32'(frame_done), 0);
    check("idle_after_clear", 32'(busy), 0);
    check("ready_after_clear", 32'(in_ready), 1);
    check("done_count", done_cnt - done0, 1);
    check("clear_count", clr_cnt - clr0, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cfg_width = 11'd4;
    cfg_height = 10'd3;
    in_valid = 1'b0;
    in_data = '0;
    in_sof = 1'b0;
    in_eol = 1'b0;
    err_clr = 1'b0;
    lb_valid_o = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_lb_reset", 32'(lb_reset), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_lb_valid", 32'(lb_valid), 0);
    check("rst_lb_img_width", 32'(lb_img_width), 0);
    check("rst_lb_img_height", 32'(lb_img_height), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err", {30'd0, err_eol, err_cfg}, 0);
    check("rst_in_ready", 32'(in_ready), 1);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("lb_reset_release", 32'(lb_reset), 0);
    step();

    // 1: continuous 4x3 frame
    run_frame(4, 3, 1'b0, -1, 1'b0);

    // 2: 4x3 frame with random input gaps
    run_frame(4, 3, 1'b1, -1, 1'b0);

    // 3: non-SOF pixels in IDLE are dropped
    got_q.delete();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(1, 255));
      in_sof   = 1'b0;
      step();
    end
    in_valid = 1'b0;
    step();
    check("resync_dropped", got_q.size(), 0);
    check("resync_idle", 32'(busy), 0);
    run_frame(4, 3, 1'b0, -1, 1'b0);

    // 4: illegal SOF sets err_cfg; set wins over a coincident clear
    cfg_width = 11'd1;
    cfg_height = 10'd3;
    in_valid = 1'b1;
    in_sof = 1'b1;
    in_data = 8'h33;
    step();
    in_valid = 1'b0;
    in_sof = 1'b0;
    @(negedge clk);
    check("err_cfg_set", 32'(err_cfg), 1);
    check("err_cfg_no_fwd", 32'(lb_valid), 0);
    check("err_cfg_idle", 32'(busy), 0);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cfg_clr", 32'(err_cfg), 0);
    step();
    cfg_width = 11'd4;
    cfg_height = 10'd1;
    in_valid = 1'b1;
    in_sof = 1'b1;
    err_clr = 1'b1;
    step();
    in_valid = 1'b0;
    in_sof = 1'b0;
    err_clr = 1'b0;
    @(negedge clk);
    check("err_cfg_set_wins", 32'(err_cfg), 1);
    check("err_cfg_h1_idle", 32'(busy), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    run_frame(2, 2, 1'b0, -1, 1'b0);

    // 5: misplaced in_eol and cfg_width changing mid-frame
    @(negedge clk);
    check("err_eol_clean", 32'(err_eol), 0);
    step();
    run_frame(4, 3, 1'b0, 2, 1'b1);
    check("err_eol_set", 32'(err_eol), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("err_eol_clr", 32'(err_eol), 0);
    step();

    // 6: reset at pixel 7 abandons the frame
    cfg_width = 11'd4;
    cfg_height = 10'd3;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_data = 8'($urandom);
      in_sof = (k == 0);
      in_eol = (k == 3);
      step();
    end
    begin
      int done0;
      done0 = done_cnt;
      reset = 1'b1;
      in_sof = 1'b0;
      in_eol = 1'b0;
      @(negedge clk);
      check("lb_reset_during_reset", 32'(lb_reset), 1);
      step();
      in_valid = 1'b0;
      @(negedge clk);
      check("mid_reset_idle", 32'(busy), 0);
      check("mid_reset_lb_valid", 32'(lb_valid), 0);
      check("mid_reset_width", 32'(lb_img_width), 0);
      step();
      reset = 1'b0;
      repeat (4) step();
      check("mid_reset_no_done", done_cnt - done0, 0);
    end
    run_frame(4, 3, 1'b1, -1, 1'b0);

    // random frame sizes, data and gaps
    for (int r = 0; r < 4; r++)
      run_frame($urandom_range(2, 7), $urandom_range(2, 5), r[0], -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
